// File: rtl/rv32c_fetch_align_buffer.sv
// Fetch alignment buffer: reads word-aligned instruction words and hands whole
// RV32C/RV32 instructions to the fetch stage through a single-entry output register.
module rv32c_fetch_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_ren,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed
);

  typedef enum logic [1:0] {FETCH, DRAIN, WAIT_OUT} state_t;
  typedef enum logic [1:0] {HOLD_EMPTY, HOLD_C16, HOLD_PART} hold_t;

  state_t      state;
  hold_t       hold_kind;
  logic [29:0] fetch_addr;
  logic        skip_low;
  logic [15:0] hold_data;
  logic [31:0] hold_pc;

  logic        complete;
  logic        slot_free;
  logic        em;
  logic [31:0] em_instr;
  logic [31:0] em_pc;
  logic        em_c;
  hold_t       nk;
  logic [15:0] nd;
  logic [31:0] np;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[0];
  assign imem_addr     = {fetch_addr, 2'b00};
  assign complete      = imem_ren && !imem_busy;
  assign slot_free     = !out_valid || out_ready;

  // Split the returned word into at most one emitted instruction plus the new hold contents.
  always_comb begin
    em       = 1'b0;
    em_instr = '0;
    em_pc    = '0;
    em_c     = 1'b0;
    nk       = HOLD_EMPTY;
    nd       = hold_data;
    np       = hold_pc;
    if (hold_kind == HOLD_PART) begin
      em       = 1'b1;
      em_instr = {imem_rdata[15:0], hold_data};
      em_pc    = hold_pc;
      nk       = (imem_rdata[17:16] != 2'b11) ? HOLD_C16 : HOLD_PART;
      nd       = imem_rdata[31:16];
      np       = {fetch_addr, 2'b10};
    end else if (skip_low) begin
      if (imem_rdata[17:16] != 2'b11) begin
        em       = 1'b1;
        em_instr = {16'h0000, imem_rdata[31:16]};
        em_pc    = {fetch_addr, 2'b10};
        em_c     = 1'b1;
      end else begin
        nk = HOLD_PART;
        nd = imem_rdata[31:16];
        np = {fetch_addr, 2'b10};
      end
    end else if (imem_rdata[1:0] != 2'b11) begin
      em       = 1'b1;
      em_instr = {16'h0000, imem_rdata[15:0]};
      em_pc    = {fetch_addr, 2'b00};
      em_c     = 1'b1;
      nk       = (imem_rdata[17:16] != 2'b11) ? HOLD_C16 : HOLD_PART;
      nd       = imem_rdata[31:16];
      np       = {fetch_addr, 2'b10};
    end else begin
      em       = 1'b1;
      em_instr = imem_rdata;
      em_pc    = {fetch_addr, 2'b00};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= FETCH;
      imem_ren       <= 1'b0;
      hold_kind      <= HOLD_EMPTY;
      hold_data      <= '0;
      hold_pc        <= '0;
      fetch_addr     <= RESET_PC[31:2];
      skip_low       <= RESET_PC[1];
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_pc         <= '0;
      out_compressed <= 1'b0;
    end else if (redirect) begin
      state          <= FETCH;
      imem_ren       <= 1'b1;
      hold_kind      <= HOLD_EMPTY;
      fetch_addr     <= redirect_pc[31:2];
      skip_low       <= redirect_pc[1];
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_pc         <= '0;
      out_compressed <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid      <= 1'b0;
        out_instr      <= '0;
        out_pc         <= '0;
        out_compressed <= 1'b0;
      end
      case (state)
        FETCH: begin
          // imem_ren is registered so it stays low while nRST is asserted; raise it here.
          imem_ren <= 1'b1;
          if (complete) begin
            fetch_addr <= fetch_addr + 30'd1;
            skip_low   <= 1'b0;
            hold_kind  <= nk;
            hold_data  <= nd;
            hold_pc    <= np;
            if (em) begin
              out_valid      <= 1'b1;
              out_instr      <= em_instr;
              out_pc         <= em_pc;
              out_compressed <= em_c;
            end
            if (nk == HOLD_C16) begin
              state    <= DRAIN;
              imem_ren <= 1'b0;
            end else if (em) begin
              state    <= WAIT_OUT;
              imem_ren <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            out_valid      <= 1'b1;
            out_instr      <= {16'h0000, hold_data};
            out_pc         <= hold_pc;
            out_compressed <= 1'b1;
            hold_kind      <= HOLD_EMPTY;
            state          <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (slot_free) begin
            state    <= FETCH;
            imem_ren <= 1'b1;
          end
        end
        default: begin
          state    <= FETCH;
          imem_ren <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32c_fetch_align_buffer.sv
// Directed bench for rv32c_fetch_align_buffer: bus responses and handshakes driven
// step by step, outputs checked against hand-computed values.
module tb_rv32c_fetch_align_buffer;

  logic        CLK;
  logic        nRST;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata;
  logic        imem_busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;

  int tests_run = 0;
  int tests_failed = 0;

  rv32c_fetch_align_buffer #(.RESET_PC(32'h80000000)) dut (
    .CLK(CLK), .nRST(nRST), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
    .imem_busy(imem_busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_compressed(out_compressed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc, input logic c);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_c"}, {31'd0, out_compressed}, {31'd0, c});
  endtask

  task automatic wait_ren(input string tag);
    int n = 0;
    while (!imem_ren && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ren"}, {31'd0, imem_ren}, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    nRST        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rdata  = '0;
    imem_busy   = 1'b1;
    out_ready   = 1'b0;
    #1;
    check("rst_ren", {31'd0, imem_ren}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_c", {31'd0, out_compressed}, 32'd0);
    tick();
    tick();
    nRST = 1'b1;

    // aligned 32-bit instruction, zero wait states
    wait_ren("t1");
    check("t1_addr", imem_addr, 32'h80000000);
    imem_rdata = 32'h00000013;
    imem_busy  = 1'b0;
    tick();
    imem_busy = 1'b1;
    check_out("t1_out", 32'h00000013, 32'h80000000, 1'b0);
    check("t1_ren_low", {31'd0, imem_ren}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_cleared", {31'd0, out_valid}, 32'd0);
    check("t1_next_ren", {31'd0, imem_ren}, 32'd1);
    check("t1_next_addr", imem_addr, 32'h80000004);

    // two compressed halfwords in one word
    do_redirect(32'h80000000);
    check("t2_addr", imem_addr, 32'h80000000);
    imem_rdata = 32'h45014501;
    imem_busy  = 1'b0;
    tick();
    imem_busy = 1'b1;
    check_out("t2_lo", 32'h00004501, 32'h80000000, 1'b1);
    check("t2_ren0", {31'd0, imem_ren}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_out("t2_hi", 32'h00004501, 32'h80000002, 1'b1);
    check("t2_ren1", {31'd0, imem_ren}, 32'd0);
    tick();
    check("t2_ren_hold", {31'd0, imem_ren}, 32'd0);
    check("t2_valid_hold", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_cleared", {31'd0, out_valid}, 32'd0);
    check("t2_next_addr", imem_addr, 32'h80000004);
    check("t2_next_ren", {31'd0, imem_ren}, 32'd1);

    // 32-bit instruction straddling two words
    do_redirect(32'h80000000);
    imem_rdata = 32'h00134501;
    imem_busy  = 1'b0;
    tick();
    imem_busy = 1'b1;
    check_out("t3_a", 32'h00004501, 32'h80000000, 1'b1);
    out_ready = 1'b1;
    tick();
    check("t3_ren", {31'd0, imem_ren}, 32'd1);
    check("t3_addr", imem_addr, 32'h80000004);
    imem_rdata = 32'h45010000;
    imem_busy  = 1'b0;
    tick();
    imem_busy = 1'b1;
    check_out("t3_b", 32'h00000013, 32'h80000002, 1'b0);
    check("t3_ren_drain", {31'd0, imem_ren}, 32'd0);
    tick();
    check_out("t3_c", 32'h00004501, 32'h80000006, 1'b1);
    tick();
    out_ready = 1'b0;
    check("t3_cleared", {31'd0, out_valid}, 32'd0);
    check("t3_next_addr", imem_addr, 32'h80000008);

    // redirect wins over a completion in the same cycle; odd-halfword restart
    imem_rdata  = 32'h00000013;
    imem_busy   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h80000102;
    tick();
    redirect  = 1'b0;
    imem_busy = 1'b1;
    check("t4_dropped", {31'd0, out_valid}, 32'd0);
    check("t4_addr", imem_addr, 32'h80000100);
    check("t4_ren", {31'd0, imem_ren}, 32'd1);
    imem_rdata = 32'h00010001;
    imem_busy  = 1'b0;
    tick();
    imem_busy = 1'b1;
    check_out("t4_out", 32'h00000001, 32'h80000102, 1'b1);
    check("t4_ren_low", {31'd0, imem_ren}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_cleared", {31'd0, out_valid}, 32'd0);
    check("t4_next_addr", imem_addr, 32'h80000104);

    // backpressure with a compressed halfword waiting in hold
    do_redirect(32'h80000000);
    imem_rdata = 32'h45014501;
    imem_busy  = 1'b0;
    tick();
    imem_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_out("t5_stall", 32'h00004501, 32'h80000000, 1'b1);
      check("t5_stall_ren", {31'd0, imem_ren}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_out("t5_hi", 32'h00004501, 32'h80000002, 1'b1);

    // asynchronous reset in the middle of a fetch
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t6_pre_ren", {31'd0, imem_ren}, 32'd1);
    check("t6_pre_addr", imem_addr, 32'h80000004);
    #2;
    nRST = 1'b0;
    #1;
    check("t6_ren_async", {31'd0, imem_ren}, 32'd0);
    check("t6_valid_async", {31'd0, out_valid}, 32'd0);
    tick();
    nRST = 1'b1;
    wait_ren("t6");
    check("t6_addr", imem_addr, 32'h80000000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
